// File: rtl/sram_port0_adapter_if.sv
// Request/grant + rvalid/rready bus into the port-0 sram adapter.
// Signal names keep the adapter's port suffixes so both ends read the same.
interface sram_port0_adapter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WMASKS = 4
);
  logic                  req_i;
  logic                  gnt_o;
  logic                  we_i;
  logic [NUM_WMASKS-1:0] be_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rvalid_o;
  logic                  rready_i;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, rready_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, rready_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_port0_adapter.sv
// Req/gnt front-end for sram port 0: issues csb0/web0 cycles and buffers dout0 in a credit FIFO.
// Define SRAM_ADPT_WR_ACK_EN to have writes take credit and return a zero-data response.
module sram_port0_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WMASKS = 4,
  parameter int RESP_DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  sram_port0_adapter_if.slave   bus,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [PW-1:0] LAST    = PW'(RESP_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(RESP_DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(RESP_DEPTH);

  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  accept, takes_credit, push, pop;
  logic [DATA_WIDTH-1:0] push_data;

  // Credit counts the slot reserved by the access still in the sram pipe.
  assign bus.gnt_o = rst_ni && (({1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q}) < DEPTH_C);
  assign accept    = bus.req_i & bus.gnt_o;

  assign sram_csb0_o   = ~accept;
  assign sram_web0_o   = ~(accept & bus.we_i);
  assign sram_wmask0_o = (accept & bus.we_i) ? bus.be_i : '0;
  assign sram_addr0_o  = bus.addr_i;
  assign sram_din0_o   = bus.wdata_i;

`ifdef SRAM_ADPT_WR_ACK_EN
  logic pend_wr_q;

  assign takes_credit = accept;
  assign push_data    = pend_wr_q ? '0 : sram_dout0_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_wr_q <= 1'b0;
    else         pend_wr_q <= accept & bus.we_i;
  end
`else
  assign takes_credit = accept & ~bus.we_i;
  assign push_data    = sram_dout0_i;
`endif

  assign rd_pend_d    = takes_credit;
  assign push         = rd_pend_q;
  assign pop          = bus.rvalid_o & bus.rready_i;
  assign bus.rvalid_o = (cnt_q != '0);
  assign bus.rdata_o  = fifo_q[rptr_q];

  assign wptr_d = push ? ((wptr_q == LAST) ? '0 : wptr_q + 1'b1) : wptr_q;
  assign rptr_d = pop  ? ((rptr_q == LAST) ? '0 : rptr_q + 1'b1) : rptr_q;
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      for (int i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      if (push) fifo_q[wptr_q] <= push_data;
    end
  end

  // Credit should make this unreachable; flag it loudly if it ever happens.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && (cnt_q == FULL_C)))
    else $error("response FIFO push while full");
endmodule

// File: tb/tb_sram_port0_adapter.sv
// Scoreboard bench for sram_port0_adapter against a behavioural 1RW sram model.
module tb_sram_port0_adapter;
  localparam int DW = 32, AW = 5, NW = 4;
`ifdef SRAM_ADPT_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  typedef struct packed {
    logic          csb;
    logic          web;
    logic [NW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } pins_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port0_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) bus ();
  logic          csb, web;
  logic [NW-1:0] wmask;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;

  sram_port0_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW), .RESP_DEPTH(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask),
    .sram_addr0_o(addr), .sram_din0_o(din), .sram_dout0_i(dout)
  );

  // sram macro model: registered read data, byte-masked write.
  logic [DW-1:0] smem [32];
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < NW; b++) if (wmask[b]) smem[addr][8*b +: 8] <= din[8*b +: 8];
      end else dout <= smem[addr];
    end
  end

  int checks = 0, errors = 0;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_q [$];

  // Drive one cycle, sample outputs before the edge, and record accepted requests.
  task automatic step(input bit req, input bit we, input logic [NW-1:0] be, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input bit rr,
                      output bit acc, output bit rv, output bit got, output logic [DW-1:0] rd,
                      output pins_t p);
    @(negedge clk);
    bus.req_i = req; bus.we_i = we; bus.be_i = be; bus.addr_i = a; bus.wdata_i = wd;
    bus.rready_i = rr;
    #1;
    acc = req && (bus.gnt_o === 1'b1);
    rv  = (bus.rvalid_o === 1'b1);
    got = rv && rr;
    rd  = bus.rdata_o;
    p   = {csb, web, wmask, addr, din};
    if (acc) begin
      if (we) begin
        for (int b = 0; b < NW; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        if (WR_ACK) exp_q.push_back('0);
      end else exp_q.push_back(ref_mem[a]);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.rready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", bus.gnt_o); end
    checks++; if (csb !== 1'b1 || web !== 1'b1 || wmask !== '0) begin
      errors++; $display("FAIL reset_sram got csb=%b web=%b wmask=%h exp 1 1 0", csb, web, wmask); end
    checks++; if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== '0) begin
      errors++; $display("FAIL reset_resp got rvalid=%b rdata=%h exp 0 0", bus.rvalid_o, bus.rdata_o); end
    @(negedge clk);
    bus.req_i = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL reset_release_gnt got %b exp 1", bus.gnt_o); end
  endtask

  task automatic test_write_read();
    bit acc, rv, got; logic [DW-1:0] rd, e; pins_t p; int n = 0;
    step(1'b1, 1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b1, acc, rv, got, rd, p);
    checks++; if (!acc) begin errors++; $display("FAIL wr_accept got 0 exp 1"); end
    checks++; if (p !== pins_t'({1'b0, 1'b0, 4'hF, 5'd5, 32'hDEADBEEF})) begin
      errors++; $display("FAIL wr_issue got %h exp %h", p, pins_t'({1'b0, 1'b0, 4'hF, 5'd5, 32'hDEADBEEF})); end
    step(1'b1, 1'b0, 4'h0, 5'd5, '0, 1'b1, acc, rv, got, rd, p);
    checks++; if (!acc || p.csb !== 1'b0 || p.web !== 1'b1 || p.wmask !== '0) begin
      errors++; $display("FAIL rd_issue got acc=%b csb=%b web=%b wmask=%h exp 1 0 1 0", acc, p.csb, p.web, p.wmask); end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rv, got, rd, p);
      if (c == 0) begin
        checks++; if (got !== WR_ACK) begin errors++; $display("FAIL wr_ack_slot got %b exp %b", got, WR_ACK); end
      end
      if (c == 1) begin
        checks++; if (!got || rd !== 32'hDEADBEEF) begin
          errors++; $display("FAIL rd_latency got valid=%b rdata=%h exp 1 deadbeef", got, rd); end
      end
      if (got) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wr_rd_extra got %h exp none", rd); end
        else begin e = exp_q.pop_front();
          if (rd !== e) begin errors++; $display("FAIL wr_rd_data got %h exp %h", rd, e); end end
      end
    end
    checks++; if (n != (WR_ACK ? 2 : 1)) begin errors++; $display("FAIL wr_rd_count got %0d exp %0d", n, WR_ACK ? 2 : 1); end
  endtask

  task automatic test_partial_write();
    bit acc, rv, got; logic [DW-1:0] rd, e, last; pins_t p;
    last = '0;
    step(1'b1, 1'b1, 4'b0101, 5'd5, 32'h11223344, 1'b1, acc, rv, got, rd, p);
    step(1'b1, 1'b1, 4'b0000, 5'd5, 32'hFFFFFFFF, 1'b1, acc, rv, got, rd, p);
    checks++; if (!acc || p.csb !== 1'b0 || p.web !== 1'b0 || p.wmask !== '0) begin
      errors++; $display("FAIL be0_issue got acc=%b csb=%b web=%b wmask=%h exp 1 0 0 0", acc, p.csb, p.web, p.wmask); end
    step(1'b1, 1'b0, 4'h0, 5'd5, '0, 1'b1, acc, rv, got, rd, p);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rv, got, rd, p);
      if (got) begin
        last = rd;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL partial_extra got %h exp none", rd); end
        else begin e = exp_q.pop_front();
          if (rd !== e) begin errors++; $display("FAIL partial_data got %h exp %h", rd, e); end end
      end
    end
    checks++; if (last !== 32'hDE22BE44) begin errors++; $display("FAIL partial_merge got %h exp de22be44", last); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL partial_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit acc, rv, got; logic [DW-1:0] rd, e; pins_t p; int n = 0, pop_at = -1, acc_at = -1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'hF, AW'(i), DW'(i), 1'b1, acc, rv, got, rd, p);
    for (int c = 0; c < 10 && (exp_q.size() != 0 || rv); c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rv, got, rd, p);
      if (got) begin checks++; e = exp_q.pop_front();
        if (rd !== e) begin errors++; $display("FAIL bp_ack got %h exp %h", rd, e); end end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, AW'(i), '0, 1'b0, acc, rv, got, rd, p);
      checks++; if (!acc) begin errors++; $display("FAIL bp_grant%0d got 0 exp 1", i); end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, '0, 5'd3, '0, 1'b0, acc, rv, got, rd, p);
      checks++; if (acc) begin errors++; $display("FAIL bp_full%0d got gnt 1 exp 0", c); end
    end
    checks++; if (!rv || rd !== 32'd0) begin errors++; $display("FAIL bp_hold got valid=%b rdata=%h exp 1 0", rv, rd); end
    for (int c = 0; c < 12 && n < 4; c++) begin
      step(acc_at < 0, 1'b0, '0, 5'd3, '0, 1'b1, acc, rv, got, rd, p);
      if (acc && acc_at < 0) acc_at = c;
      if (got) begin
        if (pop_at < 0) pop_at = c;
        n++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got %h exp none", rd); end
        else begin e = exp_q.pop_front();
          if (rd !== e || rd !== DW'(n - 1)) begin errors++; $display("FAIL bp_order got %h exp %h", rd, DW'(n - 1)); end end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", n); end
    checks++; if (acc_at != pop_at + 1) begin errors++; $display("FAIL bp_regrant got cycle %0d exp %0d", acc_at, pop_at + 1); end
  endtask

  task automatic test_stream();
    bit acc, rv, got; logic [DW-1:0] rd, e; pins_t p; int n = 0, nacc = 0;
    for (int i = 0; i < 48; i++) begin
      if (i < 32) step(1'b1, 1'b1, 4'hF, AW'(i), DW'($urandom), 1'b1, acc, rv, got, rd, p);
      else        step(1'b1, 1'b0, '0, AW'((i * 7) % 32), '0, 1'b1, acc, rv, got, rd, p);
      if (acc) nacc++;
      if (got) begin n++; checks++; e = exp_q.pop_front();
        if (rd !== e) begin errors++; $display("FAIL stream_data got %h exp %h", rd, e); end end
    end
    checks++; if (nacc != 48) begin errors++; $display("FAIL stream_grants got %0d exp 48", nacc); end
    for (int c = 0; c < 10 && (exp_q.size() != 0 || rv); c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rv, got, rd, p);
      if (got) begin n++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_extra got %h exp none", rd); end
        else begin e = exp_q.pop_front();
          if (rd !== e) begin errors++; $display("FAIL stream_data got %h exp %h", rd, e); end end
      end
    end
    checks++; if (n != (WR_ACK ? 48 : 16)) begin errors++; $display("FAIL stream_count got %0d exp %0d", n, WR_ACK ? 48 : 16); end
  endtask

  task automatic test_random();
    bit acc, rv, got; logic [DW-1:0] rd, e; pins_t p;
    for (int c = 0; c < 200 || (c < 230 && (exp_q.size() != 0 || rv)); c++) begin
      if (c < 200) step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, NW'($urandom), AW'($urandom),
                        DW'($urandom), $urandom_range(0, 1) == 1, acc, rv, got, rd, p);
      else         step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rv, got, rd, p);
      if (got) begin checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_extra got %h exp none", rd); end
        else begin e = exp_q.pop_front();
          if (rd !== e) begin errors++; $display("FAIL rand_data cycle %0d got %h exp %h", c, rd, e); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit acc, rv, got; logic [DW-1:0] rd; pins_t p; int n = 0;
    step(1'b1, 1'b0, '0, 5'd1, '0, 1'b0, acc, rv, got, rd, p);
    step(1'b1, 1'b0, '0, 5'd2, '0, 1'b0, acc, rv, got, rd, p);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (bus.gnt_o !== 1'b0 || csb !== 1'b1 || bus.rvalid_o !== 1'b0 || bus.rdata_o !== '0) begin
      errors++; $display("FAIL midrst_state got gnt=%b csb=%b rvalid=%b rdata=%h exp 0 1 0 0",
                         bus.gnt_o, csb, bus.rvalid_o, bus.rdata_o); end
    bus.req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rv, got, rd, p);
      if (rv) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL midrst_flush got %0d responses exp 0", n); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
